// File: rtl/player_controller.sv
// Player sprite controller for the maze game.
// Holds the sprite position, steps it once per frame from the direction
// buttons, freezes it when the collision block reports win or game over,
// and drives the per-pixel `player` signal for the current scan point.
module player_controller #(
    parameter logic [9:0] START_X = 10'd20,
    parameter logic [9:0] START_Y = 10'd20,
    parameter logic [9:0] SIZE    = 10'd10,
    parameter logic [9:0] STEP    = 10'd2,
    parameter logic [9:0] X_MAX   = 10'd639,
    parameter logic [9:0] Y_MAX   = 10'd479
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        win,
    input  logic        game_over,
    input  logic [9:0]  xCount,
    input  logic [9:0]  yCount,
    output logic        player,
    output logic [9:0]  player_x,
    output logic [9:0]  player_y,
    output logic [15:0] move_count,
    output logic        active
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        FROZEN = 2'd2
    } state_t;

    // Largest legal top-left coordinate that still keeps the whole sprite on screen.
    localparam logic [10:0] X_LIMIT = {1'b0, X_MAX} - {1'b0, SIZE} + 11'd1;
    localparam logic [10:0] Y_LIMIT = {1'b0, Y_MAX} - {1'b0, SIZE} + 11'd1;

    state_t      r_state;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [15:0] r_move_count;
    logic        r_active;

    logic [10:0] w_x_wide;
    logic [10:0] w_y_wide;
    logic [10:0] w_step_wide;
    logic [10:0] w_x_sum;
    logic [10:0] w_y_sum;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic [9:0]  w_x_next;
    logic [9:0]  w_y_next;
    logic        w_moved;
    logic        w_any_btn;
    logic        w_freeze;
    logic        w_in_x;
    logic        w_in_y;

    // All position arithmetic is done one bit wider so neither the step nor
    // the sprite extent can wrap around the 10-bit coordinate range.
    assign w_x_wide    = {1'b0, r_x};
    assign w_y_wide    = {1'b0, r_y};
    assign w_step_wide = {1'b0, STEP};
    assign w_x_sum     = w_x_wide + w_step_wide;
    assign w_y_sum     = w_y_wide + w_step_wide;
    assign w_x_end     = w_x_wide + {1'b0, SIZE};
    assign w_y_end     = w_y_wide + {1'b0, SIZE};

    assign w_any_btn = btn_up | btn_down | btn_left | btn_right;
    assign w_freeze  = win | game_over;

    // Candidate next position for this frame, clamped to the visible area;
    // opposing buttons on the same axis cancel out.
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (btn_left && !btn_right) begin
            w_x_next = (w_x_wide < w_step_wide) ? 10'd0 : (r_x - STEP);
        end else if (btn_right && !btn_left) begin
            w_x_next = (w_x_sum > X_LIMIT) ? X_LIMIT[9:0] : w_x_sum[9:0];
        end
        if (btn_up && !btn_down) begin
            w_y_next = (w_y_wide < w_step_wide) ? 10'd0 : (r_y - STEP);
        end else if (btn_down && !btn_up) begin
            w_y_next = (w_y_sum > Y_LIMIT) ? Y_LIMIT[9:0] : w_y_sum[9:0];
        end
    end

    assign w_moved = (w_x_next != r_x) || (w_y_next != r_y);

    // Zero-latency sprite hit test so `player` lines up with the wall pixels
    // generated for the same scan point.
    assign w_in_x = ({1'b0, xCount} >= w_x_wide) && ({1'b0, xCount} < w_x_end);
    assign w_in_y = ({1'b0, yCount} >= w_y_wide) && ({1'b0, yCount} < w_y_end);
    assign player = w_in_x && w_in_y;

    // Game state machine; position only ever changes on a frame tick so a
    // frame is never drawn with a half-updated sprite, and a freeze request
    // always beats a move arriving on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_x          <= START_X;
            r_y          <= START_Y;
            r_move_count <= 16'd0;
            r_active     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_freeze) begin
                        r_state  <= FROZEN;
                        r_active <= 1'b0;
                    end else if (frame_tick && w_any_btn) begin
                        r_state  <= PLAY;
                        r_active <= 1'b1;
                        r_x      <= w_x_next;
                        r_y      <= w_y_next;
                        if (w_moved && (r_move_count != 16'hFFFF)) begin
                            r_move_count <= r_move_count + 16'd1;
                        end
                    end
                end
                PLAY: begin
                    if (w_freeze) begin
                        r_state  <= FROZEN;
                        r_active <= 1'b0;
                    end else begin
                        r_active <= 1'b1;
                        if (frame_tick) begin
                            r_x <= w_x_next;
                            r_y <= w_y_next;
                            if (w_moved && (r_move_count != 16'hFFFF)) begin
                                r_move_count <= r_move_count + 16'd1;
                            end
                        end
                    end
                end
                FROZEN: begin
                    r_active <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign player_x   = r_x;
    assign player_y   = r_y;
    assign move_count = r_move_count;
    assign active     = r_active;

endmodule

// File: doc/player_controller.md
Name: player_controller

Overview:
- Owns the player sprite for the maze game and drives the `player` pixel signal consumed by the collision block.
- Steps the player position once per video frame from four direction buttons.
- Freezes the player as soon as the collision block reports `win` or `game_over`.
- Keeps a saturating count of frames in which the player moved, for score display.

Parameters:
- START_X, 10'd20, reset x of the sprite's top-left corner.
- START_Y, 10'd20, reset y of the sprite's top-left corner.
- SIZE, 10'd10, sprite side length in pixels (square).
- STEP, 10'd2, pixels moved per frame tick per axis.
- X_MAX, 10'd639, rightmost visible column.
- Y_MAX, 10'd479, bottom visible row.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse per frame, issued during vertical blank.
- btn_up, btn_down, btn_left, btn_right  input  1 each  level-sensitive, already debounced.
- win  input  1  from the collision block.
- game_over  input  1  from the collision block.
- xCount  input  10  current scan column.
- yCount  input  10  current scan row.
- player  output  1  high when the scan point lies inside the sprite.
- player_x  output  10  sprite left edge.
- player_y  output  10  sprite top edge.
- move_count  output  16  frames with a position change, saturating.
- active  output  1  high in the PLAY state.

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous and active-high; it overrides everything else.
- Reset values:
  - state = IDLE
  - player_x = START_X, player_y = START_Y
  - move_count = 0, active = 0
- `player` is combinational from the registered position, zero latency:
  - high iff xCount >= player_x and xCount < player_x+SIZE and yCount >= player_y and yCount < player_y+SIZE.
  - Compare in 11 bits so player_x+SIZE cannot wrap.
  - This keeps `player` aligned with the wall/border pixels at the same scan point.
- Position registers change only on a cycle where frame_tick=1, so a frame never shows a torn sprite.
- States:
  - IDLE:
    - Position held.
    - On frame_tick with at least one button high: go to PLAY and apply that tick's move.
    - win or game_over high (with or without a tick): go to FROZEN, no move.
  - PLAY:
    - active=1.
    - Each frame_tick applies one move.
    - win or game_over high: go to FROZEN next cycle, no move that cycle, even if frame_tick=1 in the same cycle (freeze has priority).
  - FROZEN:
    - active=0; position and move_count held.
    - Stays FROZEN until rst.
- Move rule per axis, evaluated on a tick:
  - up and not down: y_new = max(player_y − STEP, 0).
  - down and not up: y_new = min(player_y + STEP, Y_MAX − SIZE + 1).
  - Both or neither pressed: axis unchanged.
  - x axis is identical, using left/right and X_MAX.
  - Diagonal moves are allowed (both axes update in one tick).
- Arithmetic is 11-bit signed-safe: subtraction below 0 clamps to 0, with no 10-bit wrap to ~1023.
- move_count:
  - Increments by 1 on a tick where (x_new,y_new) ≠ (player_x,player_y).
  - A clamped no-op does not count.
  - Saturates at 16'hFFFF.
- rst mid-frame or in FROZEN returns to IDLE with the start position on the next clock edge.
- Buttons held across many ticks move STEP per tick; there is no acceleration.

Test Plan:
1. rst high 2 cycles, then low; xCount=20..29, yCount=20 → player=1 for those columns and 0 at xCount=19 and 30; player_x=20, player_y=20, active=0.
2. btn_right held, 5 frame_ticks → state goes PLAY on the 1st tick; player_x=30, player_y=20, move_count=5, active=1.
3. Position (1,20), btn_left, 2 ticks → player_x=0 after the 1st tick and 0 after the 2nd; move_count increments only once. Position (629,20), btn_right → player_x stays 630 max, no wrap.
4. In PLAY: game_over and frame_tick high in the same cycle with btn_down → player_y unchanged; FROZEN next cycle; further ticks and buttons cause no change; active=0.
5. btn_up and btn_down both held with btn_right, 1 tick → only player_x +2, y unchanged. Then rst while FROZEN → start position, move_count=0, IDLE.
6. Preload move_count near saturation (65534) via 65534 moving ticks or force → after 3 more moving ticks move_count=16'hFFFF.
